// File: rtl/ssp_tx_pkg.sv
// ssp_tx_pkg: shared constants and FSM encoding for the SSP byte transmitter.
// SSP_TX_PARITY_EN selects 9 bits per byte (8 data + odd parity).
package ssp_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ssp_state_e;

   localparam int CLK_HALF_DEF   = 4;
   localparam int FIFO_DEPTH_DEF = 4;

`ifdef SSP_TX_PARITY_EN
   localparam int BITS_PER_BYTE = 9;
`else
   localparam int BITS_PER_BYTE = 8;
`endif

endpackage

// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo: byte FIFO, power-of-two depth, wrapping pointers.
// Level is one bit wider than a pointer so full and empty are distinct.
module ssp_tx_fifo
   import ssp_tx_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [PW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == LVL_FULL);
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rp];
   assign level   = cnt;

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // storage write port
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= wdata;
   end

endmodule

// File: rtl/ssp_byte_tx.sv
// ssp_byte_tx: FIFO-fed serial byte transmitter, MSB first, gated ssp_clk.
// Define SSP_TX_PARITY_EN to append an odd-parity ninth bit per byte.
module ssp_byte_tx
   import ssp_tx_pkg::*;
#(
   parameter int CLK_HALF   = CLK_HALF_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic       ck_1356meg,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       ssp_clk,
   output logic       ssp_frame,
   output logic       ssp_din,
   output logic       busy,
   output logic [4:0] fifo_level
);

   localparam int SW = BITS_PER_BYTE;
   localparam int CW = 9;
   localparam logic [CW-1:0] HALF    = CW'(CLK_HALF);
   localparam logic [CW-1:0] PER_END = CW'(2*CLK_HALF-1);
   localparam logic [3:0]    BIT_END = 4'(SW-1);

   ssp_state_e state_q;
   ssp_state_e state_d;
   logic [CW-1:0] cyc_q;
   logic [3:0]    bit_q;
   logic [SW-1:0] sr_q;
   logic [SW-1:0] load_word;
   logic [7:0]    fifo_data;
   logic [$clog2(FIFO_DEPTH):0] lvl;
   logic pop;
   logic full;
   logic empty;
   logic per_end;
   logic last_bit;

   ssp_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (ck_1356meg),
      .rst   (rst),
      .push  (din_valid),
      .pop   (pop),
      .wdata (din),
      .rdata (fifo_data),
      .level (lvl),
      .full  (full),
      .empty (empty)
   );

`ifdef SSP_TX_PARITY_EN
   assign load_word = {fifo_data, ~^fifo_data};
`else
   assign load_word = fifo_data;
`endif

   assign per_end    = (cyc_q == PER_END);
   assign last_bit   = (bit_q == BIT_END);
   assign din_ready  = !full;
   assign busy       = (state_q != IDLE) || !empty;
   assign fifo_level = 5'(lvl);

   // state register
   always_ff @(posedge ck_1356meg) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state and pop decision; a pop only ever starts a new byte
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty && en) begin
               pop     = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (per_end && last_bit) state_d = GAP;
         end
         GAP: begin
            if (per_end) begin
               if (!empty && en) begin
                  pop     = 1'b1;
                  state_d = SHIFT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // half-period counter, bit counter and shift register
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         cyc_q <= '0;
         bit_q <= '0;
         sr_q  <= '0;
      end else if (pop) begin
         cyc_q <= '0;
         bit_q <= '0;
         sr_q  <= load_word;
      end else if (state_q != IDLE) begin
         if (per_end) begin
            cyc_q <= '0;
            if (state_q == SHIFT) begin
               bit_q <= last_bit ? 4'd0 : bit_q + 4'd1;
               sr_q  <= {sr_q[SW-2:0], 1'b0};
            end
         end else begin
            cyc_q <= cyc_q + 1'b1;
         end
      end
   end

   // registered serial outputs, all forced low outside SHIFT
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         ssp_clk   <= 1'b0;
         ssp_frame <= 1'b0;
         ssp_din   <= 1'b0;
      end else begin
         ssp_clk   <= (state_q == SHIFT) && (cyc_q < HALF);
         ssp_frame <= (state_q == SHIFT) && (bit_q == 4'd0);
         ssp_din   <= (state_q == SHIFT) && sr_q[SW-1];
      end
   end

endmodule

// File: tb/tb_ssp_byte_tx.sv
// tb_ssp_byte_tx: vector table, hand sequences and randomized scoreboard.
// Serial output is decoded back to bytes and compared with what was pushed.
module tb_ssp_byte_tx;

   localparam int CH    = 4;
   localparam int DEPTH = 4;
`ifdef SSP_TX_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif
   localparam int SPACING = NB*2*CH + 2*CH;

   logic       ck_1356meg = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic       ssp_clk;
   logic       ssp_frame;
   logic       ssp_din;
   logic       busy;
   logic [4:0] fifo_level;

   int n_pass = 0;
   int n_chk  = 0;

   ssp_byte_tx #(.CLK_HALF(CH), .FIFO_DEPTH(DEPTH)) dut (
      .ck_1356meg (ck_1356meg),
      .rst        (rst),
      .en         (en),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .ssp_clk    (ssp_clk),
      .ssp_frame  (ssp_frame),
      .ssp_din    (ssp_din),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 ck_1356meg = ~ck_1356meg;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exp);
   endtask

   // expected serial word: data MSB first, then odd parity when enabled
   function automatic logic [NB-1:0] word(input logic [7:0] b);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
`ifdef SSP_TX_PARITY_EN
      return {b, (ones % 2 == 0)};
`else
      return b;
`endif
   endfunction

   // decoder: a bit is taken on each ssp_clk falling edge
   logic [NB-1:0] rx_q[$];
   int            fr_t[$];
   int            cyc = 0;
   int            rises = 0;
   int            nbits = 0;
   logic [NB-1:0] sh = '0;
   logic          pc = 1'b0;
   logic          pf = 1'b0;

   initial forever begin
      @(negedge ck_1356meg);
      cyc++;
      if (ssp_clk && !pc) rises++;
      if (ssp_frame && !pf) fr_t.push_back(cyc);
      if (!ssp_clk && pc) begin
         if (ssp_frame) begin
            sh    = '0;
            nbits = 0;
         end
         sh = {sh[NB-2:0], ssp_din};
         nbits++;
         if (nbits == NB) begin
            rx_q.push_back(sh);
            nbits = 0;
         end
      end
      if (rst) nbits = 0;
      pc = ssp_clk;
      pf = ssp_frame;
   end

   task automatic cyc_n(input int n);
      repeat (n) @(negedge ck_1356meg);
   endtask

   task automatic wait_idle(input string nm);
      int t;
      t = 0;
      while ((busy || ssp_clk || ssp_frame) && t < 3000) begin
         @(negedge ck_1356meg);
         t++;
      end
      chk(nm, int'(t < 3000), 1);
      cyc_n(2);
   endtask

   task automatic wait_rx(input int n, input string nm);
      int t;
      t = 0;
      while (rx_q.size() < n && t < 5000) begin
         @(negedge ck_1356meg);
         t++;
      end
      chk(nm, rx_q.size(), n);
   endtask

   typedef struct {
      logic [7:0] b;
      int         ones;
   } vec_t;

   vec_t          tv[7];
   logic [7:0]    exp_q[$];
   logic [NB-1:0] wv;
   logic [3:0]    act4;
   logic [3:0]    exp4;
   int            on;
   int            j;
   int            ph;
   int            dh, fh, chh, bh;
   logic [7:0]    bq[4];

   initial begin
      tv[0] = '{8'h00, 0};
      tv[1] = '{8'hFF, 8};
      tv[2] = '{8'hA5, 4};
      tv[3] = '{8'h01, 1};
      tv[4] = '{8'h80, 1};
      tv[5] = '{8'h3C, 4};
      tv[6] = '{8'h07, 3};

      // reset state
      cyc_n(3);
      chk("rst_outs", int'({ssp_clk, ssp_frame, ssp_din, busy}), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_ready", int'(din_ready), 1);
      rst = 1'b0;
      cyc_n(2);

      // exact waveform of 0xA5, k = samples after the push edge
      en = 1'b1;
      din = 8'hA5;
      din_valid = 1'b1;
      @(negedge ck_1356meg);
      din_valid = 1'b0;
      wv = word(8'hA5);
      for (int k = 0; k <= NB*8 + 16; k++) begin
         on = int'(k >= 2 && k <= 1 + NB*8);
         j  = on != 0 ? (k - 2) / 8 : 0;
         ph = on != 0 ? (k - 2) % 8 : 0;
         exp4[3] = (on != 0) && (ph < CH);
         exp4[2] = (on != 0) && (j == 0);
         exp4[1] = (on != 0) && wv[NB-1-j];
         exp4[0] = (k <= NB*8 + 8);
         act4 = {ssp_clk, ssp_frame, ssp_din, busy};
         chk($sformatf("a5_wave_k%0d", k), int'(act4), int'(exp4));
         @(negedge ck_1356meg);
      end
      wait_idle("a5_idle");

      // vector table: one byte each, count high cycles per output
      foreach (tv[i]) begin
         rx_q.delete();
         dh = 0; fh = 0; chh = 0; bh = 0;
         din = tv[i].b;
         din_valid = 1'b1;
         @(negedge ck_1356meg);
         din_valid = 1'b0;
         for (int k = 0; k < NB*8 + 20; k++) begin
            dh  += int'(ssp_din);
            fh  += int'(ssp_frame);
            chh += int'(ssp_clk);
            bh  += int'(busy);
            @(negedge ck_1356meg);
         end
         chk($sformatf("tv%0d_count", i), rx_q.size(), 1);
         if (rx_q.size() > 0)
            chk($sformatf("tv%0d_byte", i), int'(rx_q[0]), int'(word(tv[i].b)));
         chk($sformatf("tv%0d_din_hi", i), dh,
             8 * (tv[i].ones + ((NB == 9 && tv[i].ones % 2 == 0) ? 1 : 0)));
         chk($sformatf("tv%0d_frame_hi", i), fh, 2*CH);
         chk($sformatf("tv%0d_clk_hi", i), chh, NB*CH);
         chk($sformatf("tv%0d_busy_hi", i), bh, NB*8 + 9);
         wait_idle($sformatf("tv%0d_idle", i));
      end

      // back-to-back pushes
      rx_q.delete();
      fr_t.delete();
      din = 8'h01;
      din_valid = 1'b1;
      @(negedge ck_1356meg);
      din = 8'h80;
      @(negedge ck_1356meg);
      din_valid = 1'b0;
      wait_rx(2, "b2b_count");
      if (rx_q.size() >= 2) begin
         chk("b2b_first", int'(rx_q[0]), int'(word(8'h01)));
         chk("b2b_second", int'(rx_q[1]), int'(word(8'h80)));
      end
      chk("b2b_frames", fr_t.size(), 2);
      if (fr_t.size() >= 2)
         chk("b2b_spacing", fr_t[1] - fr_t[0], SPACING);
      wait_idle("b2b_idle");

      // full FIFO with en low
      rx_q.delete();
      en = 1'b0;
      rises = 0;
      din_valid = 1'b1;
      bq[0] = 8'h11; bq[1] = 8'h22; bq[2] = 8'h33; bq[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         din = bq[i];
         @(negedge ck_1356meg);
      end
      din = 8'h55;
      chk("full_ready", int'(din_ready), 0);
      chk("full_level", int'(fifo_level), DEPTH);
      cyc_n(3);
      chk("full_level_hold", int'(fifo_level), DEPTH);
      chk("full_no_clk", rises, 0);
      chk("full_busy", int'(busy), 1);
      din_valid = 1'b0;
      en = 1'b1;
      @(negedge ck_1356meg);
      chk("full_ready_pop", int'(din_ready), 1);
      chk("full_level_pop", int'(fifo_level), DEPTH - 1);
      wait_rx(4, "full_count");
      for (int i = 0; i < 4; i++)
         if (rx_q.size() > i)
            chk($sformatf("full_order%0d", i), int'(rx_q[i]), int'(word(bq[i])));
      wait_idle("full_idle");

      // reset during bit 3 of 0xFF with two bytes queued
      rx_q.delete();
      fr_t.delete();
      din_valid = 1'b1;
      din = 8'hFF;
      @(negedge ck_1356meg);
      din = 8'hAA;
      @(negedge ck_1356meg);
      din = 8'h55;
      @(negedge ck_1356meg);
      din_valid = 1'b0;
      begin
         int t;
         t = 0;
         while (fr_t.size() == 0 && t < 200) begin
            @(negedge ck_1356meg);
            t++;
         end
         chk("mid_frame_seen", int'(fr_t.size() > 0), 1);
      end
      cyc_n(35);
      chk("mid_level_pre", int'(fifo_level), 2);
      rst = 1'b1;
      @(negedge ck_1356meg);
      chk("mid_outs", int'({ssp_clk, ssp_frame, ssp_din, busy}), 0);
      chk("mid_level", int'(fifo_level), 0);
      chk("mid_ready", int'(din_ready), 1);
      @(negedge ck_1356meg);
      rst = 1'b0;
      rises = 0;
      cyc_n(100);
      chk("mid_no_clk", rises, 0);
      chk("mid_no_byte", rx_q.size(), 0);
      chk("mid_busy", int'(busy), 0);

      // randomized traffic against the scoreboard
      rx_q.delete();
      fr_t.delete();
      exp_q.delete();
      for (int i = 0; i < 600; i++) begin
         din_valid = ($urandom_range(0, 3) != 0);
         din = 8'($urandom);
         en = ($urandom_range(0, 7) != 0);
         if (din_valid && din_ready) exp_q.push_back(din);
         @(negedge ck_1356meg);
      end
      din_valid = 1'b0;
      en = 1'b1;
      wait_rx(exp_q.size(), "rnd_count");
      for (int i = 0; i < exp_q.size(); i++)
         if (rx_q.size() > i)
            chk($sformatf("rnd_byte%0d", i), int'(rx_q[i]), int'(word(exp_q[i])));
      for (int i = 1; i < fr_t.size(); i++)
         chk($sformatf("rnd_gap%0d", i), int'(fr_t[i] - fr_t[i-1] >= SPACING), 1);
      wait_idle("rnd_idle");
      chk("rnd_level_end", int'(fifo_level), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ssp_byte_tx.md
SSP_BYTE_TX -- requirements
Module: ssp_byte_tx

Interface
REQ-001 Parameter CLK_HALF, default 4: ssp_clk half-period in ck_1356meg cycles, legal range 1..255.
REQ-002 Parameter FIFO_DEPTH, default 4: byte FIFO entries, power of two, range 2..16.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 ck_1356meg  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 en  in  1  transmit enable; gates only the start of new bytes.
REQ-007 din  in  8  byte to send to the ARM.
REQ-008 din_valid  in  1  din is valid this cycle.
REQ-009 din_ready  out  1  FIFO can accept a byte; a push occurs when din_valid and din_ready are both high.
REQ-010 ssp_clk  out  1  serial clock to the ARM.
REQ-011 ssp_frame  out  1  frame marker; high for the first bit period of each byte.
REQ-012 ssp_din  out  1  serial data to the ARM, MSB first.
REQ-013 busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-014 fifo_level  out  5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and GAP.
- IDLE -> SHIFT: FIFO non-empty and en=1; pop one byte into the shift register.
REQ-016 In SHIFT, each bit period SHALL last 2*CLK_HALF cycles.
- ssp_clk is high for the first CLK_HALF cycles and low for the remaining CLK_HALF cycles.
- ssp_din holds the bit for the whole period, so the ARM samples it on the falling edge of ssp_clk.
REQ-017 ssp_frame SHALL be high exactly during bit 7 (the first bit) and low for every other bit.
REQ-018 After the last bit, the FSM SHALL enter GAP for 2*CLK_HALF cycles with ssp_clk, ssp_frame and ssp_din all low.
REQ-019 On the last GAP cycle:
- FIFO non-empty and en=1: pop the next byte and go directly to SHIFT, giving back-to-back byte spacing of (bits*2*CLK_HALF)+2*CLK_HALF cycles.
- Otherwise: go to IDLE.
REQ-020 Latency: a push into an empty FIFO while IDLE with en=1 at edge N SHALL make the pop occur at edge N+1 and ssp_frame rise at edge N+2.
REQ-021 ssp_clk SHALL toggle only in SHIFT; in IDLE and GAP it is held low (gated clock, no free-running).
REQ-022 din_ready SHALL equal (fifo_level != FIFO_DEPTH); it is combinational from registered state only.
REQ-023 Simultaneous push and pop SHALL leave fifo_level unchanged; a push into an empty FIFO is not popped in the same cycle.
REQ-024 Pushes SHALL be accepted regardless of the en value.
REQ-025 Deasserting en mid-byte SHALL NOT truncate the byte in flight; it only blocks the next pop.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level is one bit wider than a pointer.

Reset
REQ-027 With rst high at an edge, the design SHALL take these values after that edge:
- FSM in IDLE; FIFO emptied with fifo_level=0.
- ssp_clk, ssp_frame, ssp_din and busy all 0.
- din_ready 1; bit and cycle counters 0.
REQ-028 Reset mid-byte SHALL abort the byte immediately; no partial bits are emitted after the reset edge.

Configuration
REQ-029 Macro SSP_TX_PARITY_EN, when defined, SHALL append a ninth bit after bit 0.
- The ninth bit is the odd-parity bit (~^byte) and uses the same bit period.
- Bits per byte = 9.
REQ-030 Without SSP_TX_PARITY_EN, bits per byte SHALL be 8 and no parity logic is instantiated.

Structure
REQ-031 Shared package ssp_tx_pkg SHALL hold:
- the FSM state encoding (IDLE, SHIFT, GAP);
- the default CLK_HALF and FIFO_DEPTH constants;
- the BITS_PER_BYTE constant, derived from SSP_TX_PARITY_EN.
REQ-032 The FIFO SHALL be a separate sub-module ssp_tx_fifo (push, pop, data, level, full, empty); the FSM, bit counter and half-period counter stay in ssp_byte_tx.

Verification (CLK_HALF=4, FIFO_DEPTH=4)
REQ-033 Single byte, no parity:
- Stimulus: push 0xA5 at edge 0 while idle, en=1.
- Response: ssp_frame high for edges 2..9; ssp_din = 1,0,1,0,0,1,0,1, each held 8 cycles; ssp_clk high 4 / low 4 per bit; busy falls after edge 73.
REQ-034 Back-to-back:
- Stimulus: push 0x01 then 0x80 on consecutive cycles.
- Response: the second ssp_frame rise occurs exactly 72 cycles after the first; the second byte's ssp_din goes high only in its first bit period.
REQ-035 Full FIFO:
- Stimulus: with en=0, push 0x11, 0x22, 0x33, 0x44, then present 0x55.
- Response: din_ready goes low after the 4th push; 0x55 is not accepted; fifo_level=4; ssp_clk stays 0.
- Then set en=1: bytes are emitted in the order 0x11..0x44, and din_ready rises at the first pop.
REQ-036 Reset mid-byte:
- Stimulus: assert rst during bit 3 of 0xFF with 2 bytes queued.
- Response: the next edge gives all outputs 0, fifo_level=0 and din_ready=1; no further ssp_clk edges occur.
REQ-037 Parity (SSP_TX_PARITY_EN defined):
- 0xA5 emits ninth bit 1.
- 0x07 emits ninth bit 0.
- Byte-to-byte spacing is 80 cycles.
